hs_fifo_sfifo_wr_arb: RTL and testbench
=======================================

Name: hs_fifo_sfifo_wr_arb

Overview:
Round-robin write-side arbiter that shares one hs_fifo_sfifo write port among NUM_REQ producers. It has two arbitration modes. In packet mode, a grant stays locked until the owner's last beat, so packets from different producers never interleave in the FIFO. In beat mode, a grant is bounded by MAX_BURST beats. The block sits directly in front of the FIFO write interface and forwards the granted producer's data with zero added latency.

Parameters:
NUM_REQ, 4, number of producers; range 2..16.
DATA_WIDTH, 16, payload width; must equal the FIFO data width.
EN_PACKET_MODE, 0, 1 = grant held until owner's req_last beat; 0 = beat mode.
MAX_BURST, 8, beat mode only: maximum beats per grant; 0 = unlimited. Ignored in packet mode.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  NUM_REQ  per-producer valid.
req_ready  out  NUM_REQ  per-producer ready.
req_data  in  NUM_REQ*DATA_WIDTH  packed payload; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_last  in  NUM_REQ  per-producer end-of-packet.
fifo_wr_en  out  1  FIFO write strobe.
fifo_wr_data  out  DATA_WIDTH  FIFO write data.
fifo_wr_last  out  1  FIFO last flag.
fifo_full  in  1  FIFO full.
grant_id  out  max(1,$clog2(NUM_REQ))  current or selected owner index.
grant_lock  out  1  1 while a grant is held across cycles.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, req_ready=0, fifo_wr_en=0, grant_lock=0, grant_id=0.
- Clock and reset: one clock. Reset is asynchronous and active-high; it returns every register to its reset value immediately. A reset mid-packet discards the lock, and the next grant starts from rr_ptr=0.
- Arbitration, IDLE state:
  - Combinational search for the first asserted req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - Winner W drives grant_id. Its data/last are muxed to the FIFO outputs.
  - req_ready[W] = !fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[W] & !fifo_full.
  - No valid requester: all outputs 0, state unchanged.
- Transfer definition: fifo_wr_en=1 in a cycle. Zero latency from producer to FIFO. No output registers.
- IDLE transitions on a transfer by W:
  - Packet mode, req_last[W]=0 -> LOCKED; owner=W.
  - Packet mode, req_last[W]=1 (single-beat packet) -> stay IDLE; rr_ptr=(W+1)%NUM_REQ.
  - Beat mode -> LOCKED with owner=W and beat_cnt=1, unless MAX_BURST==1, in which case stay IDLE and rr_ptr=W+1.
- LOCKED state:
  - Only owner is considered; grant_lock=1; grant_id=owner.
  - req_ready[owner] = !fifo_full.
- LOCKED release, packet mode: on a transfer with req_last=1 -> IDLE; rr_ptr=owner+1. If the owner deasserts valid mid-packet, the grant is held indefinitely (no timeout).
- LOCKED release, beat mode: beat_cnt increments per transfer. The block goes to IDLE with rr_ptr=owner+1 when either:
  - a transfer brings beat_cnt to MAX_BURST (MAX_BURST>0), or
  - a cycle occurs with req_valid[owner]=0.
  A fifo_full stall with valid still high does not release the grant.
- beat_cnt width is $clog2(MAX_BURST+1). It never wraps because the release occurs at MAX_BURST. With MAX_BURST=0 the counter saturates at its maximum and is never compared.
- Back-pressure: while fifo_full=1, no write is issued, and the owner's data/last must be held by the producer (valid/ready rule: a producer may not drop valid without a transfer).
- Simultaneous events: release and new arbitration never occur in the same cycle. The cycle after a release performs a fresh IDLE arbitration, so the previous owner has lowest priority.
- Single owner at a time: at most one req_ready bit is high in any cycle.

Test Plan:
- Packet mode, NUM_REQ=4: producers 0 and 2 each send a 3-beat packet starting in the same cycle -> FIFO receives 3 beats of P0, then 3 of P2, no interleave; rr_ptr=3 afterwards.
- Beat mode, MAX_BURST=4: producer 1 streams continuously while producer 3 waits -> writes follow 4×P1, 4×P3, 4×P1, ...; grant_lock drops for exactly one cycle at each switch.
- fifo_full asserted for 5 cycles mid-packet of P0 -> fifo_wr_en=0 and req_ready=0 throughout; owner stays 0; packet completes intact after full deasserts.
- All 4 producers valid with single-beat packets -> grant order 0,1,2,3,0,...; one write per cycle; no producer starves.
- rst asserted mid-packet (owner=2, beat 2 of 4) -> outputs 0 immediately; after release with all valid, first grant goes to producer 0.
- Beat mode, MAX_BURST=0: producer 2 deasserts valid for one cycle -> grant released; producer 3 (valid) wins next.

Source files
------------

// File: rtl/hs_fifo_sfifo_wr_arb_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and one FIFO write port.
// Producers/FIFO drive the master side; the arbiter sits on the slave side.
interface hs_fifo_sfifo_wr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
) ();
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_wr_last;
    logic                          fifo_full;
    logic [IW-1:0]                 grant_id;
    logic                          grant_lock;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_last,
        input  grant_id, grant_lock
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_last,
        output grant_id, grant_lock
    );
endinterface

// File: rtl/hs_fifo_sfifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Packet mode locks a grant until req_last; beat mode bounds a grant to MAX_BURST beats.
module hs_fifo_sfifo_wr_arb #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int EN_PACKET_MODE = 0,
    parameter int MAX_BURST      = 8
) (
    input  logic clk,
    input  logic rst,
    hs_fifo_sfifo_wr_arb_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic                  found;
    logic [IW-1:0]         win;
    logic [IW-1:0]         sel;
    logic                  active;
    logic                  wr_en;
    logic                  wr_last;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]    ready;
    logic [CW-1:0]         cnt_inc;
    logic                  rel;
    int                    idx;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        sel     = (state_q == LOCKED) ? owner_q : win;
        active  = !rst && ((state_q == LOCKED) || found);
        ready   = '0;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        wr_data = '0;
        if (active) begin
            ready[sel] = !bus.fifo_full;
            wr_en      = bus.req_valid[sel] && !bus.fifo_full;
            wr_last    = bus.req_last[sel];
            wr_data    = bus.req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_last = wr_last;
    assign bus.fifo_wr_data = wr_data;
    assign bus.grant_id     = active ? sel : '0;
    assign bus.grant_lock   = !rst && (state_q == LOCKED);

    // With MAX_BURST=0 the counter saturates instead of wrapping.
    always_comb begin
        if (MAX_BURST == 0 && beat_cnt_q == '1) cnt_inc = beat_cnt_q;
        else                                    cnt_inc = beat_cnt_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        rel        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (EN_PACKET_MODE != 0) begin
                        if (bus.req_last[win]) begin
                            rr_ptr_d = nxt(win);
                        end else begin
                            state_d = LOCKED;
                            owner_d = win;
                        end
                    end else if (MAX_BURST == 1) begin
                        rr_ptr_d = nxt(win);
                    end else begin
                        state_d    = LOCKED;
                        owner_d    = win;
                        beat_cnt_d = CW'(1);
                    end
                end
            end
            LOCKED: begin
                if (EN_PACKET_MODE != 0) begin
                    rel = wr_en && wr_last;
                end else if (!bus.req_valid[owner_q]) begin
                    rel = 1'b1;
                end else if (wr_en) begin
                    beat_cnt_d = cnt_inc;
                    rel = (MAX_BURST > 0) && (cnt_inc == CW'(MAX_BURST));
                end
            end
            default: state_d = IDLE;
        endcase
        // Release never overlaps a new grant; next cycle rearbitrates past the owner.
        if (rel) begin
            state_d    = IDLE;
            rr_ptr_d   = nxt(owner_q);
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule

// File: tb/tb_hs_fifo_sfifo_wr_arb.sv
// Directed bench: packet mode, beat mode MAX_BURST=4 and MAX_BURST=0 instances.
// Producers advance one beat per observed valid&ready; grants are hand-computed.
module tb_hs_fifo_sfifo_wr_arb;
    logic clk;
    logic rst;

    logic [3:0]  vld  [3];
    logic [63:0] dat  [3];
    logic [3:0]  lst  [3];
    logic        full [3];
    logic [3:0]  rdy  [3];
    logic        wen  [3];
    logic [15:0] wdat [3];
    logic        wlst [3];
    logic [1:0]  gid  [3];
    logic        lck  [3];

    int       beat [3][4];
    int       len  [3][4];
    logic     sgl  [3];
    logic [3:0] gap [3];
    int       n_chk;
    int       n_fail;

    hs_fifo_sfifo_wr_arb_if #(.NUM_REQ(4), .DATA_WIDTH(16)) ip ();
    hs_fifo_sfifo_wr_arb_if #(.NUM_REQ(4), .DATA_WIDTH(16)) ib ();
    hs_fifo_sfifo_wr_arb_if #(.NUM_REQ(4), .DATA_WIDTH(16)) iz ();

    hs_fifo_sfifo_wr_arb #(
        .NUM_REQ(4), .DATA_WIDTH(16), .EN_PACKET_MODE(1), .MAX_BURST(8)
    ) u_pkt (.clk(clk), .rst(rst), .bus(ip));
    hs_fifo_sfifo_wr_arb #(
        .NUM_REQ(4), .DATA_WIDTH(16), .EN_PACKET_MODE(0), .MAX_BURST(4)
    ) u_b4 (.clk(clk), .rst(rst), .bus(ib));
    hs_fifo_sfifo_wr_arb #(
        .NUM_REQ(4), .DATA_WIDTH(16), .EN_PACKET_MODE(0), .MAX_BURST(0)
    ) u_b0 (.clk(clk), .rst(rst), .bus(iz));

    assign ip.req_valid = vld[0];
    assign ip.req_data  = dat[0];
    assign ip.req_last  = lst[0];
    assign ip.fifo_full = full[0];
    assign rdy[0]  = ip.req_ready;
    assign wen[0]  = ip.fifo_wr_en;
    assign wdat[0] = ip.fifo_wr_data;
    assign wlst[0] = ip.fifo_wr_last;
    assign gid[0]  = ip.grant_id;
    assign lck[0]  = ip.grant_lock;

    assign ib.req_valid = vld[1];
    assign ib.req_data  = dat[1];
    assign ib.req_last  = lst[1];
    assign ib.fifo_full = full[1];
    assign rdy[1]  = ib.req_ready;
    assign wen[1]  = ib.fifo_wr_en;
    assign wdat[1] = ib.fifo_wr_data;
    assign wlst[1] = ib.fifo_wr_last;
    assign gid[1]  = ib.grant_id;
    assign lck[1]  = ib.grant_lock;

    assign iz.req_valid = vld[2];
    assign iz.req_data  = dat[2];
    assign iz.req_last  = lst[2];
    assign iz.fifo_full = full[2];
    assign rdy[2]  = iz.req_ready;
    assign wen[2]  = iz.fifo_wr_en;
    assign wdat[2] = iz.fifo_wr_data;
    assign wlst[2] = iz.fifo_wr_last;
    assign gid[2]  = iz.grant_id;
    assign lck[2]  = iz.grant_lock;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
        end
    endtask

    task automatic drive(input int m);
        for (int i = 0; i < 4; i++) begin
            vld[m][i] = (beat[m][i] < len[m][i]) && !gap[m][i];
            dat[m][i*16 +: 16] = 16'(i * 256 + beat[m][i]);
            lst[m][i] = sgl[m] || (beat[m][i] == len[m][i] - 1);
        end
    endtask

    task automatic adv(input int m);
        for (int i = 0; i < 4; i++)
            if (vld[m][i] && rdy[m][i]) beat[m][i]++;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 4; i++) begin
                beat[m][i] = 0;
                len[m][i]  = 0;
            end
            sgl[m]  = 1'b0;
            gap[m]  = 4'b0;
            full[m] = 1'b0;
            drive(m);
        end
    endtask

    task automatic do_rst();
        rst = 1'b1;
        clr();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_out(input int m, input string t, input int c,
                              input logic e_wen, input int e_gid,
                              input logic e_lck, input logic [3:0] e_rdy,
                              input logic [15:0] e_dat, input logic e_lst);
        string p;
        p = $sformatf("%s[%0d]", t, c);
        chk({p, ".wen"}, 32'(wen[m]), 32'(e_wen));
        chk({p, ".gid"}, 32'(gid[m]), 32'(e_gid));
        chk({p, ".lock"}, 32'(lck[m]), 32'(e_lck));
        chk({p, ".rdy"}, 32'(rdy[m]), 32'(e_rdy));
        if (e_wen) begin
            chk({p, ".data"}, 32'(wdat[m]), 32'(e_dat));
            chk({p, ".last"}, 32'(wlst[m]), 32'(e_lst));
        end
    endtask

    task automatic cyc(input int m, input string t, input int c,
                       input logic e_wen, input int e_gid, input logic e_lck,
                       input logic [3:0] e_rdy, input logic [15:0] e_dat,
                       input logic e_lst);
        drive(m);
        #4;
        expect_out(m, t, c, e_wen, e_gid, e_lck, e_rdy, e_dat, e_lst);
        adv(m);
    endtask

    initial begin
        int g;
        int b;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;

        do_rst();
        #4;
        for (int m = 0; m < 3; m++)
            expect_out(m, "reset", m, 1'b0, 0, 1'b0, 4'b0, 16'h0, 1'b0);
        @(posedge clk);
        #1;

        // Packet mode: P0 and P2 3-beat packets, no interleave.
        len[0][0] = 3;
        len[0][2] = 3;
        for (int c = 0; c < 6; c++) begin
            g = (c < 3) ? 0 : 2;
            b = c % 3;
            cyc(0, "pkt", c, 1'b1, g, b != 0, 4'(1 << g),
                16'(g * 256 + b), b == 2);
        end
        cyc(0, "pkt", 6, 1'b0, 0, 1'b0, 4'b0, 16'h0, 1'b0);
        len[0][0] = 4;
        len[0][3] = 1;
        cyc(0, "rr3", 0, 1'b1, 3, 1'b0, 4'b1000, 16'h0300, 1'b1);
        cyc(0, "rr3", 1, 1'b1, 0, 1'b0, 4'b0001, 16'h0003, 1'b1);
        cyc(0, "rr3", 2, 1'b0, 0, 1'b0, 4'b0, 16'h0, 1'b0);

        // FIFO full for 5 cycles mid-packet of P0, P1 waiting.
        do_rst();
        len[0][0] = 4;
        len[0][1] = 1;
        cyc(0, "full", 0, 1'b1, 0, 1'b0, 4'b0001, 16'h0000, 1'b0);
        cyc(0, "full", 1, 1'b1, 0, 1'b1, 4'b0001, 16'h0001, 1'b0);
        full[0] = 1'b1;
        for (int c = 2; c < 7; c++)
            cyc(0, "full", c, 1'b0, 0, 1'b1, 4'b0, 16'h0, 1'b0);
        full[0] = 1'b0;
        cyc(0, "full", 7, 1'b1, 0, 1'b1, 4'b0001, 16'h0002, 1'b0);
        cyc(0, "full", 8, 1'b1, 0, 1'b1, 4'b0001, 16'h0003, 1'b1);
        cyc(0, "full", 9, 1'b1, 1, 1'b0, 4'b0010, 16'h0100, 1'b1);
        cyc(0, "full", 10, 1'b0, 0, 1'b0, 4'b0, 16'h0, 1'b0);

        // All four producers with single-beat packets: 0,1,2,3,0,...
        do_rst();
        sgl[0] = 1'b1;
        for (int i = 0; i < 4; i++) len[0][i] = 2;
        for (int c = 0; c < 8; c++) begin
            g = c % 4;
            cyc(0, "rr4", c, 1'b1, g, 1'b0, 4'(1 << g),
                16'(g * 256 + c / 4), 1'b1);
        end
        cyc(0, "rr4", 8, 1'b0, 0, 1'b0, 4'b0, 16'h0, 1'b0);

        // Reset mid-packet of P2, then all valid restarts at P0.
        do_rst();
        len[0][2] = 4;
        cyc(0, "rmid", 0, 1'b1, 2, 1'b0, 4'b0100, 16'h0200, 1'b0);
        drive(0);
        #4;
        expect_out(0, "rmid", 1, 1'b1, 2, 1'b1, 4'b0100, 16'h0201, 1'b0);
        rst = 1'b1;
        #1;
        expect_out(0, "rmid", 2, 1'b0, 0, 1'b0, 4'b0, 16'h0, 1'b0);
        clr();
        for (int i = 0; i < 4; i++) len[0][i] = 4;
        drive(0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, "rmid", 3, 1'b1, 0, 1'b0, 4'b0001, 16'h0000, 1'b0);

        // Beat mode MAX_BURST=4: P1 and P3 alternate in bursts of 4.
        do_rst();
        len[1][1] = 40;
        len[1][3] = 40;
        for (int c = 0; c < 12; c++) begin
            g = ((c % 8) < 4) ? 1 : 3;
            b = (c / 8) * 4 + c % 4;
            cyc(1, "burst", c, 1'b1, g, (c % 4) != 0, 4'(1 << g),
                16'(g * 256 + b), 1'b0);
        end

        // Beat mode MAX_BURST=0: a one-cycle valid gap releases P2.
        do_rst();
        len[2][2] = 40;
        len[2][3] = 40;
        cyc(2, "mb0", 0, 1'b1, 2, 1'b0, 4'b0100, 16'h0200, 1'b0);
        cyc(2, "mb0", 1, 1'b1, 2, 1'b1, 4'b0100, 16'h0201, 1'b0);
        cyc(2, "mb0", 2, 1'b1, 2, 1'b1, 4'b0100, 16'h0202, 1'b0);
        gap[2] = 4'b0100;
        cyc(2, "mb0", 3, 1'b0, 2, 1'b1, 4'b0100, 16'h0, 1'b0);
        gap[2] = 4'b0;
        cyc(2, "mb0", 4, 1'b1, 3, 1'b0, 4'b1000, 16'h0300, 1'b0);
        cyc(2, "mb0", 5, 1'b1, 3, 1'b1, 4'b1000, 16'h0301, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
